cash_payout: RTL

Payout dispenser for the lottery datapath. It sits downstream of `cash` and consumes its BCD result (`Eur100`/`Eur010`/`Eur001`) and the `winner`/`not_a_win` flags. It then issues the won amount as a sequence of individual 100/10/1-euro notes to a dispenser over a valid/ack handshake, keeping a running paid total. A per-note acknowledge timeout and BCD legality checks protect against a stuck or corrupt dispense.

---
 rtl/lottery_pkg.sv | 23 ++
 rtl/payout_digit_cnt.sv | 27 ++
 rtl/cash_payout.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lottery_pkg.sv
// Shared types and constants for the lottery datapath.
package lottery_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPay100,
    StPay10,
    StPay1,
    StFin
  } payout_state_t;

  localparam logic [1:0] NOTE_NONE = 2'b00;
  localparam logic [1:0] NOTE_1    = 2'b01;
  localparam logic [1:0] NOTE_10   = 2'b10;
  localparam logic [1:0] NOTE_100  = 2'b11;

  localparam logic [9:0] DENOM_1   = 10'd1;
  localparam logic [9:0] DENOM_10  = 10'd10;
  localparam logic [9:0] DENOM_100 = 10'd100;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/payout_digit_cnt.sv
// Loadable 4-bit down-counter holding the notes still owed for one denomination.
module payout_digit_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= din;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/cash_payout.sv
// Pays a BCD cash amount as individual 100/10/1 notes over a valid/ack handshake,
// with a per-note acknowledge timeout and input legality checks.
module cash_payout
  import lottery_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       winner,
  input  logic       not_a_win,
  input  logic [2:0] Eur100,
  input  logic [3:0] Eur010,
  input  logic [3:0] Eur001,
  output logic       note_valid,
  output logic [1:0] note_type,
  input  logic       note_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] paid_total
);

  localparam logic [9:0] TmoLimit = 10'(ACK_TIMEOUT);

  payout_state_t state_q, state_d, after;
  logic          err_q, err_d;
  logic [9:0]    paid_q, paid_d;
  logic [9:0]    tmo_q, tmo_d;
  logic [9:0]    denom;
  logic          load, dec100, dec10, dec1, last;
  logic [3:0]    cnt100, cnt10, cnt1;
  logic          zero100, zero10, zero1;

  payout_digit_cnt u_cnt100 (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .din  ({1'b0, Eur100}),
    .dec  (dec100),
    .cnt  (cnt100),
    .zero (zero100)
  );

  payout_digit_cnt u_cnt10 (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .din  (Eur010),
    .dec  (dec10),
    .cnt  (cnt10),
    .zero (zero10)
  );

  payout_digit_cnt u_cnt1 (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .din  (Eur001),
    .dec  (dec1),
    .cnt  (cnt1),
    .zero (zero1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      paid_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      paid_q  <= paid_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    paid_d     = paid_q;
    tmo_d      = tmo_q;
    load       = 1'b0;
    dec100     = 1'b0;
    dec10      = 1'b0;
    dec1       = 1'b0;
    note_valid = 1'b0;
    note_type  = NOTE_NONE;
    denom      = '0;
    last       = 1'b0;
    after      = StFin;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          load   = 1'b1;
          err_d  = 1'b0;
          paid_d = '0;
          tmo_d  = '0;
          if ((Eur010 > BCD_MAX) || (Eur001 > BCD_MAX) || (winner == not_a_win)) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else if (!winner) begin
            state_d = StFin;
          end else if (Eur100 != 3'd0) begin
            state_d = StPay100;
          end else if (Eur010 != 4'd0) begin
            state_d = StPay10;
          end else if (Eur001 != 4'd0) begin
            state_d = StPay1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StPay100: begin
        note_valid = 1'b1;
        note_type  = NOTE_100;
        denom      = DENOM_100;
        dec100     = note_ack;
        last       = (cnt100 == 4'd1);
        after      = !zero10 ? StPay10 : (!zero1 ? StPay1 : StFin);
      end
      StPay10: begin
        note_valid = 1'b1;
        note_type  = NOTE_10;
        denom      = DENOM_10;
        dec10      = note_ack;
        last       = (cnt10 == 4'd1);
        after      = !zero1 ? StPay1 : StFin;
      end
      StPay1: begin
        note_valid = 1'b1;
        note_type  = NOTE_1;
        denom      = DENOM_1;
        dec1       = note_ack;
        last       = (cnt1 == 4'd1);
        after      = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared handshake/timeout handling for all paying states; a transfer wins over timeout.
    if (note_valid) begin
      if (note_ack) begin
        tmo_d  = '0;
        paid_d = paid_q + denom;
        if (last) begin
          state_d = after;
        end
      end else if ((tmo_q + 10'd1) == TmoLimit) begin
        err_d   = 1'b1;
        tmo_d   = '0;
        state_d = StFin;
      end else begin
        tmo_d = tmo_q + 10'd1;
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign err        = err_q;
  assign paid_total = paid_q;

endmodule
